// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one sequential divider among N_REQ clients.
// Optional build macro DIV_ARB_ZERO_GUARD_EN: a zero divisor is answered locally (all ones, err=1).
module divider_arbiter #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_dividend,
    input  logic [N_REQ*WIDTH-1:0] req_divisor,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    output logic                   div_start,
    input  logic                   div_busy,
    input  logic                   div_ready,
    input  logic [WIDTH-1:0]       div_quotient
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   last, owner, pick, cand;
    logic            pick_valid, zero_skip;
    logic [WIDTH-1:0] pick_dividend, pick_divisor;

    // Scan from the farthest candidate to the nearest so the nearest set req after 'last' wins.
    always_comb begin
        pick_valid    = 1'b0;
        pick          = '0;
        cand          = '0;
        pick_dividend = '0;
        pick_divisor  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IW'(i)) begin
                pick_dividend = req_dividend[i*WIDTH +: WIDTH];
                pick_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef DIV_ARB_ZERO_GUARD_EN
    assign zero_skip = (pick_divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last         <= IW'(N_REQ - 1);
            owner        <= '0;
            grant        <= '0;
            done         <= '0;
            result       <= '0;
            err          <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_start    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid && !div_busy) begin
                        owner        <= pick;
                        grant        <= N_REQ'(1) << pick;
                        div_dividend <= pick_dividend;
                        div_divisor  <= pick_divisor;
                        if (zero_skip) begin
                            result <= '1;
                            err    <= 1'b1;
                            done   <= N_REQ'(1) << pick;
                            state  <= DONE;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_start <= 1'b0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A fast divider may report ready without ever showing busy.
                    if (div_ready) begin
                        result <= div_quotient;
                        done   <= grant;
                        state  <= DONE;
                    end else if (div_busy) begin
                        state <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (div_ready) begin
                        result <= div_quotient;
                        done   <= grant;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                    err   <= 1'b0;
                    last  <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus randomized batches against a
// round-robin / integer-division reference model, with a behavioural divider.
module tb_divider_arbiter;
    localparam int N = 2;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_dividend = '0;
    logic [N*W-1:0] req_divisor = '0;
    logic [N-1:0]   grant, done;
    logic [W-1:0]   result, div_dividend, div_divisor;
    logic           err, div_start, div_busy;
    logic           div_ready = 1'b0;
    logic [W-1:0]   div_quotient = '0;
    logic           m_busy = 1'b0;
    logic           ext_busy = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int starts = 0;
    int dones = 0;
    int lat = 4;
    bit fast = 1'b0;
    int last_w = N - 1;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    assign div_busy = m_busy | ext_busy;

    always #5 clk = ~clk;

    divider_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .grant(grant), .done(done), .result(result), .err(err),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_start(div_start), .div_busy(div_busy), .div_ready(div_ready),
        .div_quotient(div_quotient)
    );

    always @(posedge clk) begin
        if (div_start) starts <= starts + 1;
        if (|done) dones <= dones + 1;
    end

    // Behavioural divider: busy for lat+1 cycles (or never, when fast), then a one-cycle ready.
    bit m_act = 1'b0;
    int m_cnt = 0;
    logic [W-1:0] m_q = '0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            div_ready = 1'b0;
            if (m_act) begin
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    div_ready = 1'b1;
                    div_quotient = m_q;
                    m_act = 1'b0;
                end else begin
                    m_cnt--;
                end
            end else if (div_start) begin
                m_act = 1'b1;
                m_busy = !fast;
                m_cnt = lat;
                m_q = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] pend, input int lw);
        for (int k = 1; k <= N; k++)
            if (pend[(lw + k) % N]) return (lw + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[c] = a;
        opb[c] = b;
        req_dividend[c*W +: W] = a;
        req_divisor[c*W +: W] = b;
        req[c] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ext_busy = 1'b0;
        for (int c = 0; c < 200 && m_act; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_w = N - 1;
    endtask

    // Serve n_ops operations; clients in 'hold' keep requesting after their done.
    task automatic serve(input int n_ops, input logic [N-1:0] hold);
        logic [N-1:0] pend;
        logic [W-1:0] exp_q;
        int exp_w, who, s0, exp_s, exp_e;
        pend = req;
        s0 = starts;
        for (int op = 0; op < n_ops; op++) begin
            exp_w = rr_pick(pend, last_w);
            who = -1;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (done != '0) begin
                    for (int i = 0; i < N; i++) if (done[i]) who = i;
                    break;
                end
            end
            if (who < 0) begin
                check("done_timeout", 0, 1);
                break;
            end
            exp_q = (opb[exp_w] == '0) ? '1 : opa[exp_w] / opb[exp_w];
`ifdef DIV_ARB_ZERO_GUARD_EN
            exp_e = (opb[exp_w] == '0) ? 1 : 0;
            exp_s = (opb[exp_w] == '0) ? 0 : 1;
`else
            exp_e = 0;
            exp_s = 1;
`endif
            check("done_onehot", 32'($onehot(done)), 1);
            check("winner", who, exp_w);
            check("grant_at_done", grant, done);
            check("result", result, exp_q);
            check("err", err, exp_e);
            check("start_count", starts - s0, exp_s);
            if (!hold[who]) begin
                req[who] = 1'b0;
                pend[who] = 1'b0;
            end
            last_w = who;
            @(negedge clk);
            check("done_pulse_width", done, 0);
            check("grant_released", grant, 0);
            s0 = starts;
        end
    endtask

    initial begin
        int d0, s0, mask;
        logic [W-1:0] a, b;

        // Reset state
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_start", div_start, 0);
        check("rst_opa", div_dividend, 0);
        check("rst_opb", div_divisor, 0);
        do_reset();

        // 1) single client, slow divider, operands changed after grant
        lat = 16; fast = 1'b0;
        set_req(0, 100, 4);
        for (int c = 0; c < 20 && grant == '0; c++) @(negedge clk);
        check("t1_grant", grant, 1);
        check("t1_opa", div_dividend, 100);
        check("t1_opb", div_divisor, 4);
        req_dividend[0 +: W] = 7;
        req_divisor[0 +: W] = 1;
        serve(1, '0);

        // 2) simultaneous requests after reset: client 0 first
        do_reset();
        lat = 3;
        set_req(0, 360, 6);
        set_req(1, 50, 5);
        serve(2, '0);

        // 3) both held continuously: strict alternation 0,1,0,1
        do_reset();
        lat = 2;
        set_req(0, 1000, 10);
        set_req(1, 999, 3);
        serve(4, 2'b11);
        req = '0;

        // 4) no arbitration while the divider reports busy
        do_reset();
        ext_busy = 1'b1;
        s0 = starts;
        set_req(1, 77, 7);
        repeat (4) @(negedge clk);
        check("t4_no_grant", grant, 0);
        check("t4_no_start", starts - s0, 0);
        ext_busy = 1'b0;
        @(negedge clk);
        check("t4_grant", grant, 2'b10);
        serve(1, '0);

        // 5) reset in WAIT_READY discards the in-flight result
        do_reset();
        lat = 16; fast = 1'b0;
        set_req(0, 100, 4);
        repeat (6) @(negedge clk);
        d0 = dones;
        rst = 1'b1;
        #1;
        check("t5_grant", grant, 0);
        check("t5_done", done, 0);
        check("t5_result", result, 0);
        check("t5_start", div_start, 0);
        check("t5_opa", div_dividend, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_w = N - 1;
        for (int c = 0; c < 100 && m_act; c++) @(negedge clk);
        check("t5_no_done", dones - d0, 0);
        serve(1, '0);

        // 6) zero divisor from client 1
        do_reset();
        lat = 2;
        set_req(1, 1234, 0);
        serve(1, '0);

        // Randomized batches
        do_reset();
        for (int it = 0; it < 20; it++) begin
            mask = $urandom_range(1, (1 << N) - 1);
            lat = $urandom_range(0, 6);
            fast = 1'($urandom_range(0, 1));
            for (int c = 0; c < N; c++) begin
                if (mask[c]) begin
                    a = W'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
                    set_req(c, a, b);
                end
            end
            serve($countones(mask), '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
